// File: rtl/seq_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_if
//  Description : Request/response bundle for the sequential multiplier.
//                master = requester (drives operands and start),
//                slave  = multiplier (drives product, busy, done).
//  Signals     : start        request a multiply (sampled only when idle)
//                is_signed    1 = two's-complement operands, 0 = unsigned
//                multiplier   operand A, WIDTH bits
//                multiplicand operand B, WIDTH bits
//                product      registered 2*WIDTH-bit result
//                busy         operation in progress
//                done         one-cycle completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   is_signed;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplicand;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;
    logic                   done;

    modport master (
        output start,
        output is_signed,
        output multiplier,
        output multiplicand,
        input  product,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  is_signed,
        input  multiplier,
        input  multiplicand,
        output product,
        output busy,
        output done
    );
endinterface : seq_multiplier_if
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Shift-and-add sequential multiplier, one multiplier bit per
//                clock, LSB first. Supports unsigned and two's-complement
//                operands. Result is exact (2*WIDTH bits).
//  Parameters  : WIDTH  operand width in bits, legal range 2..32
//  Ports       : clk    rising-edge clock
//                reset  synchronous, active-high reset
//                bus    seq_multiplier_if.slave (start, is_signed,
//                       multiplier, multiplicand -> product, busy, done)
//  Options     : MULT_ZERO_SKIP_EN - when defined, a request with a zero
//                operand bypasses the bit-serial loop and completes with
//                product = 0 one cycle after the start edge.
//  Timing      : start accepted at edge k -> done high during the cycle
//                after edge k+WIDTH+1 (single cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           reset,
    seq_multiplier_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH:0]   c_ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [CNT_W-1:0]       r_count;
    logic [WIDTH:0]         r_acc_hi;      // upper half, one extra bit for carry/sign
    logic [WIDTH-1:0]       r_acc_lo;      // lower half, initially the multiplier
    logic [WIDTH-1:0]       r_mcand;
    logic                   r_signed;
    logic [2*WIDTH-1:0]     r_product;

    logic                   w_zero_skip;
    logic                   w_bit;
    logic                   w_last;
    logic [WIDTH:0]         w_mcand_ext;
    logic [WIDTH:0]         w_addend;
    logic [WIDTH:0]         w_sum;
    logic                   w_fill;

    // ------------------------------------------------------------------------
    // Zero-operand shortcut detection
    // ------------------------------------------------------------------------
`ifdef MULT_ZERO_SKIP_EN
    assign w_zero_skip = (bus.multiplier == '0) || (bus.multiplicand == '0);
`else
    assign w_zero_skip = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // CALC stays one extra cycle after the last bit (count == 0) to move the
    // finished accumulator into the product register, so DONE is entered
    // WIDTH+1 edges after the start edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start)        w_state_next = S_CALC;
            S_CALC: if (r_count == '0)    w_state_next = S_DONE;
            S_DONE:                       w_state_next = S_IDLE;
            default:                      w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit-serial datapath
    // On the multiplier MSB of a signed operation the multiplicand carries
    // negative weight, so it is subtracted instead of added.
    // ------------------------------------------------------------------------
    always_comb begin
        w_bit       = r_acc_lo[0];
        w_last      = (r_count == c_CNT_ONE);
        w_mcand_ext = r_signed ? {r_mcand[WIDTH-1], r_mcand} : {1'b0, r_mcand};
        w_addend    = '0;
        if (w_bit) begin
            if (r_signed && w_last) begin
                w_addend = ~w_mcand_ext + c_ONE_EXT;
            end else begin
                w_addend = w_mcand_ext;
            end
        end
        w_sum  = r_acc_hi + w_addend;
        // Arithmetic shift keeps the sign; in unsigned mode bit WIDTH of the
        // sum is the carry and a zero is shifted in above it.
        w_fill = r_signed ? w_sum[WIDTH] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_mcand   <= '0;
            r_signed  <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_signed  <= bus.is_signed;
                        r_acc_hi  <= '0;
                        r_product <= '0;
                        if (w_zero_skip) begin
                            // Empty accumulator and zero count: the next CALC
                            // cycle finalises immediately with a zero product.
                            r_mcand  <= '0;
                            r_acc_lo <= '0;
                            r_count  <= '0;
                        end else begin
                            r_mcand  <= bus.multiplicand;
                            r_acc_lo <= bus.multiplier;
                            r_count  <= c_CNT_LOAD;
                        end
                    end
                end
                S_CALC: begin
                    if (r_count != '0) begin
                        r_acc_hi <= {w_fill, w_sum[WIDTH:1]};
                        r_acc_lo <= {w_sum[0], r_acc_lo[WIDTH-1:1]};
                        r_count  <= r_count - c_CNT_ONE;
                    end else begin
                        r_product <= {r_acc_hi[WIDTH-1:0], r_acc_lo};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.product = r_product;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Scoreboard bench for seq_multiplier (WIDTH = 8). Requests
//                push {expected product, expected done edge} into a queue;
//                a negedge monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_cnt;
    int   total;
    int   bad;
    exp_t sb[$];
    logic [2*W-1:0] last_exp;

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference: plain integer multiply of the operands interpreted per mode.
    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        longint x;
        longint y;
        longint p;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        p = x * y;
        return p[2*W-1:0];
    endfunction

    function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == '0 || b == '0) return 1;
`endif
        return W + 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {63'd0, bus.done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("product", {48'd0, bus.product}, {48'd0, e.prod});
                check("done_latency", 64'(edge_cnt), 64'(e.due));
                check("busy_at_done", {63'd0, bus.busy}, 64'd1);
            end
        end
    end

    // Drive one request for one cycle, then scramble the operands while busy.
    task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        @(negedge clk);
        bus.start        = 1'b1;
        bus.is_signed    = s;
        bus.multiplier   = a;
        bus.multiplicand = b;
        e.prod   = ref_mul(s, a, b);
        e.due    = edge_cnt + 1 + latency(a, b);
        last_exp = e.prod;
        sb.push_back(e);
        @(negedge clk);
        bus.start        = 1'b0;
        bus.is_signed    = 1'($urandom);
        bus.multiplier   = W'($urandom);
        bus.multiplicand = W'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
        check("busy_after_done", {63'd0, bus.busy}, 64'd0);
        check("product_hold", {48'd0, bus.product}, {48'd0, last_exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        total            = 0;
        bad              = 0;
        edge_cnt         = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.is_signed    = 1'b0;
        bus.multiplier   = '0;
        bus.multiplicand = '0;
        repeat (3) @(negedge clk);
        check("reset_product", {48'd0, bus.product}, 64'd0);
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        reset = 1'b0;

        // Directed cases with literal expectations
        start_op(1'b0, 8'hFF, 8'hFF); wait_idle();
        check("u_ff_ff", {48'd0, bus.product}, 64'hFE01);
        start_op(1'b1, 8'h80, 8'h80); wait_idle();
        check("s_80_80", {48'd0, bus.product}, 64'h4000);
        start_op(1'b1, 8'hFD, 8'h05); wait_idle();
        check("s_fd_05", {48'd0, bus.product}, 64'hFFF1);
        start_op(1'b0, 8'hFD, 8'h05); wait_idle();
        check("u_fd_05", {48'd0, bus.product}, 64'h04F1);
        start_op(1'b1, 8'h7F, 8'h80); wait_idle();
        check("s_7f_80", {48'd0, bus.product}, 64'hC080);

        // Start during CALC is ignored, operands included
        start_op(1'b0, 8'd12, 8'd10);
        repeat (2) @(negedge clk);
        bus.start        = 1'b1;
        bus.multiplier   = 8'd3;
        bus.multiplicand = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        check("ignored_start", {48'd0, bus.product}, 64'h0078);
        repeat (15) @(negedge clk);

        // Reset mid-CALC aborts, and wins over a simultaneous start
        @(negedge clk);
        bus.start        = 1'b1;
        bus.is_signed    = 1'b0;
        bus.multiplier   = 8'h55;
        bus.multiplicand = 8'h33;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        check("abort_product", {48'd0, bus.product}, 64'd0);
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        start_op(1'b0, 8'd7, 8'd6); wait_idle();
        check("after_abort", {48'd0, bus.product}, 64'h002A);

        // Zero operands
        start_op(1'b0, 8'h00, 8'hAB); wait_idle();
        start_op(1'b1, 8'hAB, 8'h00); wait_idle();

        // Randomized, including back-to-back requests
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) a = '0;
            start_op(1'($urandom), a, b);
            wait_idle();
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_multiplier
`default_nettype wire
